clock_monitor: RTL and testbench

//  Measures a clock-like signal produced by a generator (free-running toggle
//  or divided clock) against the system clock. Reports high time, low time
//  and period in system-clock cycles, and flags period-out-of-tolerance and

---
 rtl/clock_monitor.sv | 197 +++++++++++++++++++
 tb/tb_clock_monitor.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/clock_monitor.sv
// clock_monitor
//   Measures a clock-like signal against the system clock. It reports the high
//   time, low time and period of sig_in in system-clock cycles. It also raises
//   sticky flags when a period is out of tolerance or when sig_in stops toggling.
//
// Ports
//   clock       in   system clock, all logic on posedge
//   reset       in   synchronous, active-high
//   enable      in   1 = monitor active, 0 = return to idle
//   sig_in      in   monitored signal, asynchronous to clock
//   clr_err     in   one-cycle pulse, clears the sticky error flags
//   high_time   out  last measured high phase, in cycles
//   low_time    out  last measured low phase, in cycles
//   period      out  high_time + low_time of the last full period (saturating)
//   meas_valid  out  one-cycle pulse when period is updated
//   period_err  out  sticky, a period fell outside EXP_PERIOD +/- TOL
//   stuck_err   out  sticky, no sig_in edge for TIMEOUT cycles
//   edge_count  out  rising edges seen while enabled, wraps

module clock_monitor #(
   parameter int unsigned CNT_W      = 16,
   parameter int unsigned EXP_PERIOD = 10,
   parameter int unsigned TOL        = 1,
   parameter int unsigned TIMEOUT    = 64
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             sig_in,
   input  logic             clr_err,
   output logic [CNT_W-1:0] high_time,
   output logic [CNT_W-1:0] low_time,
   output logic [CNT_W-1:0] period,
   output logic             meas_valid,
   output logic             period_err,
   output logic             stuck_err,
   output logic [CNT_W-1:0] edge_count
);

   localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W:0] HI_LIM = (CNT_W+1)'(EXP_PERIOD + TOL);
   localparam logic [CNT_W:0] LO_LIM =
      (EXP_PERIOD > TOL) ? (CNT_W+1)'(EXP_PERIOD - TOL) : '0;

   typedef enum logic [1:0] {StIdle, StSync, StHigh, StLow} state_e;

   state_e state_q, state_d;

   logic s1_q, s2_q, s3_q;
   logic rise, fall;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic [CNT_W-1:0] high_q, high_d;
   logic [CNT_W-1:0] low_q, low_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic             mvalid_q, mvalid_d;
   logic             perr_q, perr_d;
   logic             stuck_q, stuck_d;
   logic [CNT_W-1:0] edges_q, edges_d;

   logic [CNT_W:0]   sum_full;
   logic [CNT_W-1:0] sum_sat;
   logic             out_of_tol;
   logic             timeout_hit;

   assign rise = s2_q & ~s3_q;
   assign fall = ~s2_q & s3_q;

   // Period sum is one bit wider so an overflow can be clamped to all-ones.
   assign sum_full   = {1'b0, high_q} + {1'b0, cnt_q};
   assign sum_sat    = sum_full[CNT_W] ? '1 : sum_full[CNT_W-1:0];
   assign out_of_tol = ({1'b0, sum_sat} > HI_LIM) || ({1'b0, sum_sat} < LO_LIM);

   // Timer holds cycles since the last edge; the TIMEOUT-th edgeless cycle trips it.
   assign timeout_hit = ~(rise | fall) && (timer_q == TMR_W'(TIMEOUT - 1));

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      timer_d  = timer_q;
      high_d   = high_q;
      low_d    = low_q;
      period_d = period_q;
      mvalid_d = 1'b0;
      perr_d   = perr_q;
      stuck_d  = stuck_q;
      edges_d  = edges_q;

      // Clear first so that a simultaneous error event below wins.
      if (clr_err) begin
         perr_d  = 1'b0;
         stuck_d = 1'b0;
      end

      if (state_q == StIdle) begin
         cnt_d   = '0;
         timer_d = '0;
         if (enable) begin
            state_d = StSync;
         end
      end else if (!enable) begin
         // Any partial measurement is dropped on the way back to idle.
         state_d = StIdle;
         cnt_d   = '0;
         timer_d = '0;
      end else begin
         if (rise || fall) begin
            cnt_d = CNT_W'(1);
         end else if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
         end

         if (rise || fall || timeout_hit) begin
            timer_d = '0;
         end else begin
            timer_d = timer_q + TMR_W'(1);
         end

         if (rise) begin
            edges_d = edges_q + CNT_W'(1);
         end

         unique case (state_q)
            StSync: begin
               if (rise) begin
                  state_d = StHigh;
               end
            end
            StHigh: begin
               if (fall) begin
                  high_d  = cnt_q;
                  state_d = StLow;
               end
            end
            StLow: begin
               if (rise) begin
                  low_d    = cnt_q;
                  period_d = sum_sat;
                  mvalid_d = 1'b1;
                  if (out_of_tol) begin
                     perr_d = 1'b1;
                  end
                  state_d = StHigh;
               end
            end
            default: ;
         endcase

         if (timeout_hit) begin
            stuck_d = 1'b1;
            state_d = StSync;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= StIdle;
         s1_q     <= 1'b0;
         s2_q     <= 1'b0;
         s3_q     <= 1'b0;
         cnt_q    <= '0;
         timer_q  <= '0;
         high_q   <= '0;
         low_q    <= '0;
         period_q <= '0;
         mvalid_q <= 1'b0;
         perr_q   <= 1'b0;
         stuck_q  <= 1'b0;
         edges_q  <= '0;
      end else begin
         state_q  <= state_d;
         s1_q     <= sig_in;
         s2_q     <= s1_q;
         s3_q     <= s2_q;
         cnt_q    <= cnt_d;
         timer_q  <= timer_d;
         high_q   <= high_d;
         low_q    <= low_d;
         period_q <= period_d;
         mvalid_q <= mvalid_d;
         perr_q   <= perr_d;
         stuck_q  <= stuck_d;
         edges_q  <= edges_d;
      end
   end

   assign high_time  = high_q;
   assign low_time   = low_q;
   assign period     = period_q;
   assign meas_valid = mvalid_q;
   assign period_err = perr_q;
   assign stuck_err  = stuck_q;
   assign edge_count = edges_q;

endmodule

// File: tb/tb_clock_monitor.sv
// tb_clock_monitor
//   Directed bench for clock_monitor. Stimulus pushes the expected measurement
//   of each full period into a queue, and a monitor compares the queued value
//   whenever meas_valid is seen.

module tb_clock_monitor;

   localparam int unsigned CNT_W = 16;

   logic             clock = 1'b0;
   logic             reset;
   logic             enable;
   logic             sig_in;
   logic             clr_err;
   logic [CNT_W-1:0] high_time;
   logic [CNT_W-1:0] low_time;
   logic [CNT_W-1:0] period;
   logic             meas_valid;
   logic             period_err;
   logic             stuck_err;
   logic [CNT_W-1:0] edge_count;

   typedef struct {
      int unsigned hi;
      int unsigned lo;
      int unsigned per;
      int unsigned perr;
   } meas_t;

   meas_t sb_q[$];
   int    n_checks = 0;
   int    n_fail   = 0;

   clock_monitor #(
      .CNT_W      (CNT_W),
      .EXP_PERIOD (10),
      .TOL        (1),
      .TIMEOUT    (64)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .enable     (enable),
      .sig_in     (sig_in),
      .clr_err    (clr_err),
      .high_time  (high_time),
      .low_time   (low_time),
      .period     (period),
      .meas_valid (meas_valid),
      .period_err (period_err),
      .stuck_err  (stuck_err),
      .edge_count (edge_count)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // Each period: high for h cycles, low for l cycles; a trailing rise closes
   // the last period so n periods yield n measurements.
   task automatic run_wave(input int h, input int l, input int n, input int perr);
      meas_t m;
      for (int i = 0; i < n; i++) begin
         m.hi   = h;
         m.lo   = l;
         m.per  = h + l;
         m.perr = perr;
         sb_q.push_back(m);
         sig_in = 1'b1;
         cycles(h);
         sig_in = 1'b0;
         cycles(l);
      end
      sig_in = 1'b1;
      cycles(4);
   endtask

   task automatic start_mon();
      sig_in = 1'b0;
      enable = 1'b1;
      cycles(3);
   endtask

   task automatic finish_test(input string name);
      enable = 1'b0;
      cycles(4);
      check({name, "_sb_drained"}, sb_q.size(), 0);
   endtask

   // Monitor: compares every presented measurement against the scoreboard.
   initial begin
      meas_t e;
      forever begin
         @(negedge clock);
         if (meas_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_meas: got period %0d, expected no measurement", period);
            end else begin
               e = sb_q.pop_front();
               check("high_time", high_time, e.hi);
               check("low_time", low_time, e.lo);
               check("period", period, e.per);
               check("period_err", period_err, e.perr);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      reset   = 1'b1;
      enable  = 1'b0;
      sig_in  = 1'b0;
      clr_err = 1'b0;
      cycles(3);
      check("rst_high_time", high_time, 0);
      check("rst_period", period, 0);
      check("rst_meas_valid", meas_valid, 0);
      check("rst_errs", {period_err, stuck_err}, 0);
      check("rst_edge_count", edge_count, 0);
      reset = 1'b0;
      cycles(2);

      // 1: 50% duty, nominal period
      start_mon();
      run_wave(5, 5, 3, 0);
      finish_test("t1");
      check("t1_edges", edge_count, 4);
      check("t1_idle_hold_high", high_time, 5);

      // 2: 3/7 duty
      start_mon();
      run_wave(3, 7, 2, 0);
      finish_test("t2");
      check("t2_edges", edge_count, 7);

      // 3: period 12 is out of tolerance; clr_err clears it
      start_mon();
      run_wave(6, 6, 2, 1);
      finish_test("t3");
      check("t3_edges", edge_count, 10);
      check("t3_perr_sticky", period_err, 1);
      clr_err = 1'b1;
      cycles(1);
      clr_err = 1'b0;
      check("t3_perr_cleared", period_err, 0);

      // 4: stuck low, then toggling resumes
      sig_in = 1'b0;
      enable = 1'b1;
      cycles(60);
      check("t4_not_stuck_yet", stuck_err, 0);
      cycles(10);
      check("t4_stuck", stuck_err, 1);
      run_wave(5, 5, 2, 0);
      finish_test("t4");
      check("t4_edges", edge_count, 13);

      // 5: enable dropped mid-HIGH, period discarded
      start_mon();
      sig_in = 1'b1;
      cycles(3);
      enable = 1'b0;
      cycles(3);
      sig_in = 1'b0;
      cycles(3);
      start_mon();
      run_wave(4, 6, 1, 0);
      finish_test("t5");
      check("t5_edges", edge_count, 16);

      // 6: reset during LOW aborts and clears everything
      start_mon();
      sig_in = 1'b1;
      cycles(5);
      sig_in = 1'b0;
      cycles(4);
      reset = 1'b1;
      cycles(1);
      check("t6_rst_high", high_time, 0);
      check("t6_rst_low", low_time, 0);
      check("t6_rst_period", period, 0);
      check("t6_rst_stuck", stuck_err, 0);
      check("t6_rst_edges", edge_count, 0);
      reset = 1'b0;
      cycles(3);
      run_wave(5, 5, 1, 0);
      finish_test("t6");
      check("t6_edges", edge_count, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
